// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: opcode encodings, FSM state type and opcode classification
// helpers shared by the alu_mdu top and its iterative multiply/divide unit.
// Optional overflow output in the top is enabled by the macro ALU_MDU_OVF_EN.
package alu_mdu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes that normally run through the iterative unit.
  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Opcodes whose operands are treated as two's complement by the MDU.
  function automatic logic op_is_signed_mdu(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: unsigned radix-2 iterative datapath shared by multiply
// (shift-add) and divide (restoring). One step per cycle for WIDTH cycles.
// hi/lo present the post-step value, so they hold the final result in the
// same cycle that done is high.
module mdu_iter #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // mul: r_hi = partial product high, r_lo = multiplier shifting out, r_m = multiplicand
  // div: r_hi = partial remainder,    r_lo = dividend -> quotient,     r_m = divisor
  logic             r_busy;
  logic             r_is_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;

  assign w_add   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {WIDTH{1'b0}})};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};

  // One multiply or divide step from the current register state.
  always_comb begin
    w_hi_nx = w_add[WIDTH:1];
    w_lo_nx = {w_add[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_diff[WIDTH]) begin
        w_hi_nx = w_shift[WIDTH-1:0];
      end else begin
        w_hi_nx = w_diff[WIDTH-1:0];
      end
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  assign done = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign hi   = w_hi_nx;
  assign lo   = w_lo_nx;

  // Operand load on start, then WIDTH steps; reset abandons any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_is_div <= is_div;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= is_div ? a_mag : b_mag;
      r_m      <= is_div ? b_mag : a_mag;
    end else if (r_busy) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with iterative multiply/divide, valid/ready in and
// out. Single-cycle ops register on the accepting edge; MUL/DIV take WIDTH
// cycles in mdu_iter. Define ALU_MDU_OVF_EN to add the registered ovf output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | may accept; also holds single-cycle results until consumed
// ST_MUL  | multiply iterating in mdu_iter
// ST_DIV  | divide iterating in mdu_iter
// ST_DONE | MUL/DIV result held, waiting for out_ready
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             z
`ifdef ALU_MDU_OVF_EN
  ,
  output logic             ovf
`endif
);

  import alu_mdu_pkg::*;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  state_t             w_state_nx;

  logic               r_valid;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_y_hi;
  logic               r_z;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_accept;
  logic               w_div_op;
  logic               w_div0;
  logic               w_div_ovf;
  logic               w_iter_op;
  logic               w_start;
  logic               w_sc_load;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_sc_y;
  logic [WIDTH-1:0]   w_sc_hi;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_done;
  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_ld;
  logic [WIDTH-1:0]   w_ld_y;
  logic [WIDTH-1:0]   w_ld_hi;

`ifdef ALU_MDU_OVF_EN
  logic               r_ovf;
  logic               r_mul_s;
  logic               w_sc_ovf;
  logic               w_mul_ovf;
  logic               w_ld_ovf;
`endif

  assign in_ready  = !rst && (r_state == ST_IDLE) && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign w_div_op  = op_is_div(op);
  assign w_div0    = w_div_op && (b == '0);
  assign w_div_ovf = (op == OP_DIV) && (a == MIN_VAL) && (b == {WIDTH{1'b1}});
  assign w_iter_op = op_is_iter(op) && !w_div0 && !w_div_ovf;
  assign w_start   = w_accept && w_iter_op;
  assign w_sc_load = w_accept && !w_iter_op;

  assign w_shamt = b[SHW-1:0];
  assign w_add   = a + b;
  assign w_sub   = a - b;

  // Single-cycle results, including the divide special cases.
  always_comb begin
    w_sc_y  = '0;
    w_sc_hi = '0;
    case (op)
      OP_ADD:  w_sc_y = w_add;
      OP_SUB:  w_sc_y = w_sub;
      OP_AND:  w_sc_y = a & b;
      OP_OR:   w_sc_y = a | b;
      OP_XOR:  w_sc_y = a ^ b;
      OP_NOR:  w_sc_y = ~(a | b);
      OP_SLT:  w_sc_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_sc_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_sc_y = a << w_shamt;
      OP_SRL:  w_sc_y = a >> w_shamt;
      OP_SRA:  w_sc_y = $signed(a) >>> w_shamt;
      OP_DIV, OP_DIVU: begin
        if (w_div0) begin
          w_sc_y  = {WIDTH{1'b1}};
          w_sc_hi = a;
        end else begin
          w_sc_y  = MIN_VAL;
          w_sc_hi = '0;
        end
      end
      default: begin
        w_sc_y  = '0;
        w_sc_hi = '0;
      end
    endcase
  end

`ifdef ALU_MDU_OVF_EN
  // Signed overflow flags for the single-cycle arithmetic ops.
  always_comb begin
    w_sc_ovf = 1'b0;
    if (op == OP_ADD) begin
      w_sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
    end else if (op == OP_SUB) begin
      w_sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

  assign w_a_neg = op_is_signed_mdu(op) && a[WIDTH-1];
  assign w_b_neg = op_is_signed_mdu(op) && b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // Sign corrections captured at accept, applied when the unit finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end

`ifdef ALU_MDU_OVF_EN
  // Only signed MUL reports product overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_s <= 1'b0;
    end else if (w_start) begin
      r_mul_s <= (op == OP_MUL);
    end
  end
`endif

  mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .is_div (w_div_op),
    .a_mag  (w_a_mag),
    .b_mag  (w_b_mag),
    .done   (w_done),
    .hi     (w_it_hi),
    .lo     (w_it_lo)
  );

  assign w_prod_fix = r_neg_q ? (~{w_it_hi, w_it_lo} + 1'b1) : {w_it_hi, w_it_lo};
  assign w_quo_fix  = r_neg_q ? (~w_it_lo + 1'b1) : w_it_lo;
  assign w_rem_fix  = r_neg_r ? (~w_it_hi + 1'b1) : w_it_hi;

`ifdef ALU_MDU_OVF_EN
  assign w_mul_ovf = r_mul_s &&
                     (w_prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_fix[WIDTH-1]}});
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and output-register load selection.
  always_comb begin
    w_state_nx = r_state;
    w_ld       = 1'b0;
    w_ld_y     = w_sc_y;
    w_ld_hi    = w_sc_hi;
`ifdef ALU_MDU_OVF_EN
    w_ld_ovf   = w_sc_ovf;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nx = w_div_op ? ST_DIV : ST_MUL;
        end else if (w_sc_load) begin
          w_ld = 1'b1;
        end
      end
      ST_MUL: begin
        if (w_done) begin
          w_ld       = 1'b1;
          w_ld_y     = w_prod_fix[WIDTH-1:0];
          w_ld_hi    = w_prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_MDU_OVF_EN
          w_ld_ovf   = w_mul_ovf;
`endif
          w_state_nx = ST_DONE;
        end
      end
      ST_DIV: begin
        if (w_done) begin
          w_ld       = 1'b1;
          w_ld_y     = w_quo_fix;
          w_ld_hi    = w_rem_fix;
`ifdef ALU_MDU_OVF_EN
          w_ld_ovf   = 1'b0;
`endif
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Output registers: load a new result, otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_y_hi  <= '0;
      r_z     <= 1'b1;
`ifdef ALU_MDU_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_ld) begin
      r_valid <= 1'b1;
      r_y     <= w_ld_y;
      r_y_hi  <= w_ld_hi;
      r_z     <= (w_ld_y == '0);
`ifdef ALU_MDU_OVF_EN
      r_ovf   <= w_ld_ovf;
`endif
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign z         = r_z;
`ifdef ALU_MDU_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
